toeplitz_out_ctrl: RTL

Output sequencer for the Toeplitz hash result path. It waits for a held 3072-bit hash result from the hash core and kicks the 32-bit word serializer once per block. It then drains the serializer's small FIFO into a valid/ready stream toward the host link and acknowledges the hash core once the result has been captured. It allows only one block in flight, so the serializer FIFO can never overflow.

---
 rtl/toeplitz_pkg.sv | 19 +
 rtl/toeplitz_skid2.sv | 59 +++++
 rtl/toeplitz_out_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/toeplitz_pkg.sv
// Shared definitions for the Toeplitz hash output path: FSM encoding, block geometry
// and the header word layout used when TOEP_OUT_HDR_EN is defined.
package toeplitz_pkg;

  localparam int WORDS_PER_BLOCK = 96;
  localparam int DATA_W          = 32;

  localparam logic [15:0] HDR_MAGIC = 16'hA5C3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_KICK  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [DATA_W-1:0] hdr_word(input logic [15:0] cnt);
    return {HDR_MAGIC, cnt};
  endfunction

endpackage

// File: rtl/toeplitz_skid2.sv
// Two-entry valid/ready buffer between the serializer FIFO read port and the stream.
// Exposes occupancy so the controller can budget outstanding FIFO reads.
module toeplitz_skid2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occ
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         pop;

  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = head;

  // The caller never pushes into a full buffer; a push at occ==2 without a pop is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head <= push_data;
          end else if (occ == 2'd1) begin
            tail <= push_data;
          end
          if (occ != 2'd2) begin
            occ <= occ + 2'd1;
          end
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/toeplitz_out_ctrl.sv
// Output sequencer: kicks the word serializer once per held hash result, drains its FIFO
// into a valid/ready stream and acks the hash core. Optional header word: TOEP_OUT_HDR_EN.
module toeplitz_out_ctrl #(
  parameter int WORDS_PER_BLOCK = toeplitz_pkg::WORDS_PER_BLOCK,
  parameter int DATA_W          = toeplitz_pkg::DATA_W,
  parameter int CNT_W           = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              enable,
  input  logic              hash_valid,
  output logic              hash_ack,
  output logic              fifo_write,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] out_data,
  output logic              input_read,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  block_count,
  output logic              ser_rst,
  output logic [1:0]        fsm_state
);
  import toeplitz_pkg::*;

`ifdef TOEP_OUT_HDR_EN
  localparam int FRAME_LEN = WORDS_PER_BLOCK + 1;
`else
  localparam int FRAME_LEN = WORDS_PER_BLOCK;
`endif
  localparam int RD_W   = $clog2(WORDS_PER_BLOCK + 1);
  localparam int BEAT_W = $clog2(FRAME_LEN + 1);

  // Stream handshake: a beat transfers on any rising edge where m_valid && m_ready;
  // while m_valid && !m_ready, m_data and m_last are held unchanged.

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [RD_W-1:0]   rd_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              rd_pending;
  logic              kick_d;
  logic [1:0]        occ;
  logic [2:0]        credit_used;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              accept;
  logic              last_beat;

  assign fsm_state  = state;
  assign ser_rst    = ~rst;
  assign fifo_write = (state == ST_KICK);
  assign busy       = (state == ST_KICK) || (state == ST_DRAIN);
  assign accept     = m_valid && m_ready;
  assign last_beat  = (beat_cnt == BEAT_W'(FRAME_LEN - 1));
  assign m_last     = m_valid && last_beat;

  // Entries held after this cycle's pop plus the read whose word lands next cycle;
  // counting the pop keeps one word per cycle flowing at full rate.
  assign credit_used = {1'b0, occ} - {2'b0, accept} + {2'b0, rd_pending};
  assign input_read  = (state == ST_DRAIN) && !fifo_empty && (credit_used < 3'd2) &&
                       (rd_cnt < RD_W'(WORDS_PER_BLOCK));

`ifdef TOEP_OUT_HDR_EN
  // The header enters the empty buffer during KICK, ahead of any FIFO word.
  assign push      = rd_pending || (state == ST_KICK);
  assign push_data = rd_pending ? out_data : hdr_word(16'(block_count));
`else
  assign push      = rd_pending;
  assign push_data = out_data;
`endif

  toeplitz_skid2 #(
    .W(DATA_W)
  ) u_skid (
    .clk       (clk_in),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_ready (m_ready),
    .occ       (occ)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (enable && hash_valid) state_next = ST_KICK;
      ST_KICK:  state_next = ST_DRAIN;
      ST_DRAIN: if (accept && last_beat) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rd_cnt      <= '0;
      beat_cnt    <= '0;
      rd_pending  <= 1'b0;
      kick_d      <= 1'b0;
      hash_ack    <= 1'b0;
      block_count <= '0;
    end else begin
      state      <= state_next;
      rd_pending <= input_read;
      // Ack two cycles after the kick, once the serializer has captured the result.
      kick_d     <= (state == ST_KICK);
      hash_ack   <= kick_d;
      if (state == ST_KICK) begin
        rd_cnt   <= '0;
        beat_cnt <= '0;
      end else begin
        if (input_read) begin
          rd_cnt <= rd_cnt + RD_W'(1);
        end
        if (accept && (state == ST_DRAIN)) begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
      if (state == ST_DONE) begin
        block_count <= block_count + CNT_W'(1);
      end
    end
  end

endmodule
